load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the pipeline's execute/memory stage and OnChipDataMemory; sole master of the memory's address/write/size/sign-extend inputs.
- Accepts one load/store request per valid/ready handshake and validates it: funct3 legality, natural alignment, address range.
- Drives the single memory access, captures load data, and returns a registered response to writeback, with fault status.
- Backpressure from writeback stalls the unit; no request is dropped or duplicated.

Parameters:
- ADDR_WIDTH, 11, byte-address width of OnChipDataMemory; legal range 0 .. 2**ADDR_WIDTH-1.
- DATA_WIDTH, 64, data width; fixed at 64, not to be overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_isStore  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 funct3. [1:0] = size (0=B, 1=H, 2=W, 3=D); [2] = unsigned (loads only).
- req_addr  in  64  effective byte address.
- req_storeData  in  64  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  writeback accepts the response.
- resp_loadData  out  64  sign/zero-extended load result; 0 for stores and faults.
- resp_fault  out  1  request faulted; no memory side effect.
- resp_faultCause  out  2  0 = none, 1 = illegal funct3, 2 = misaligned, 3 = access fault.
- mem_address  out  ADDR_WIDTH  to OnChipDataMemory address.
- mem_writeData  out  64  to OnChipDataMemory writeData.
- mem_signExtended  out  1  to OnChipDataMemory signExtended.
- mem_writeSize  out  2  to OnChipDataMemory writeSize.
- mem_writeEnable  out  1  to OnChipDataMemory writeEnable.
- mem_readData  in  64  from OnChipDataMemory readData (combinational read, little-endian).

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - resp_valid, resp_fault, resp_faultCause, resp_loadData = 0.
  - All mem_* outputs = 0; mem_writeEnable deasserts without waiting for a clock edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake, latch isStore, funct3, addr[ADDR_WIDTH-1:0], storeData, and the fault check result.
  - Faulting request -> RESP, with no memory access. Otherwise -> ACCESS.
- Fault checks, in priority order (highest first):
  - Illegal funct3 (cause 1): store with funct3[2]=1, or load funct3=3'b111.
  - Misaligned (cause 2): addr mod (1<<size) != 0.
  - Access fault (cause 3): addr[63:ADDR_WIDTH] != 0.
- ACCESS (exactly one cycle):
  - Drive mem_address = latched addr and mem_writeSize = size.
  - Loads: mem_signExtended = ~funct3[2].
  - Stores: mem_writeData = storeData and mem_writeEnable = 1. The memory commits the write on the edge that ends ACCESS.
  - Loads: mem_readData is captured into resp_loadData on that same edge.
  - -> RESP with resp_valid = 1.
- RESP:
  - resp_* outputs held stable while resp_valid && !resp_ready.
  - req_ready = resp_ready.
  - On resp handshake with no new request: -> IDLE, resp_valid = 0.
  - On resp handshake plus a simultaneous req handshake: latch the new request and go directly to ACCESS (or back to RESP if it faults). No bubble through IDLE.
- mem_writeEnable is 1 only in ACCESS for a non-faulting store. Each accepted store causes exactly one write.
- Outside ACCESS, mem_* outputs hold their last values, except mem_writeEnable, which is 0.
- Latency: request handshake at edge E0, response valid after E1. Non-faulting throughput is one access per 2 cycles with resp_ready held high.
- Reset asserted during ACCESS of a store: no write occurs, and the request is discarded.
- Store response: resp_loadData = 0, resp_fault = 0.

Test Plan:
1. Store D: funct3=3, addr=0, data=0x0123456789ABCDEF. Then load LBU at addr 0..7 -> resp_loadData = 0xEF, 0xCD, 0xAB, 0x89, 0x67, 0x45, 0x23, 0x01 (little-endian). Then LD at 0 -> 0x0123456789ABCDEF.
2. Store B 0x80 at addr 16. LB at 16 -> 0xFFFFFFFFFFFFFF80; LBU at 16 -> 0x80. Each response is valid exactly one cycle after ACCESS.
3. Fault cases, each with resp_fault = 1, resp_loadData = 0, and mem_writeEnable never asserted:
   - Store H at addr 3 -> cause 2.
   - LD at addr 0x800 -> cause 3.
   - Store with funct3=3'b100 -> cause 1.
   - Misaligned and out of range together, e.g. addr 0x801 H -> cause 2.
4. resp_ready held low for 4 cycles after a LW response:
   - resp_valid and resp_loadData stay stable.
   - req_ready stays 0, and a pending req_valid is not accepted.
   - On release, the queued request is accepted the same cycle and its ACCESS follows immediately.
5. Assert reset mid-ACCESS of store W 0xDEADBEEF at addr 32:
   - mem_writeEnable drops immediately.
   - A subsequent LW at 32 returns the old contents.
   - resp_valid = 0 during and after reset.
6. Back-to-back: four loads with req_valid and resp_ready held high -> one response every 2 cycles, in order, none lost or duplicated.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: validates one load/store request at a time, drives OnChipDataMemory for a
// single ACCESS cycle and returns a registered, fault-annotated response to writeback.
module load_store_unit #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_isStore,
  input  logic [2:0]            req_funct3,
  input  logic [63:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_storeData,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_loadData,
  output logic                  resp_fault,
  output logic [1:0]            resp_faultCause,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_signExtended,
  output logic [1:0]            mem_writeSize,
  output logic                  mem_writeEnable,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Cause codes in priority order: illegal funct3, misaligned, outside the memory.
  function automatic logic [1:0] check_fault(input logic is_store, input logic [2:0] f3,
                                             input logic [63:0] addr);
    logic [2:0] mask;
    logic [1:0] cause;
    case (f3[1:0])
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    if ((is_store && f3[2]) || (!is_store && (f3 == 3'b111))) begin
      cause = 2'd1;
    end else if ((addr[2:0] & mask) != 3'b000) begin
      cause = 2'd2;
    end else if (addr[63:ADDR_WIDTH] != '0) begin
      cause = 2'd3;
    end else begin
      cause = 2'd0;
    end
    return cause;
  endfunction

  state_e                  state_q, state_d;
  logic                    is_store_q, is_store_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_fault_q, resp_fault_d;
  logic [1:0]              resp_cause_q, resp_cause_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_sext_q, mem_sext_d;
  logic [1:0]              mem_size_q, mem_size_d;
  logic                    mem_we_q, mem_we_d;
  logic                    req_fire_s;
  logic                    resp_fire_s;
  logic [1:0]              req_cause_s;

  always_comb begin
    req_ready   = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    req_fire_s  = req_valid && req_ready;
    resp_fire_s = resp_valid_q && resp_ready;
    req_cause_s = check_fault(req_isStore, req_funct3, req_addr);
  end

  // A new request may be taken from IDLE or from RESP in the same cycle the old response retires.
  always_comb begin
    state_d       = state_q;
    is_store_d    = is_store_q;
    resp_valid_d  = resp_valid_q;
    resp_fault_d  = resp_fault_q;
    resp_cause_d  = resp_cause_q;
    resp_data_d   = resp_data_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_sext_d    = mem_sext_q;
    mem_size_d    = mem_size_q;
    mem_we_d      = 1'b0;
    if (req_fire_s) begin
      if (req_cause_s == 2'd0) begin
        state_d       = ACCESS;
        is_store_d    = req_isStore;
        resp_valid_d  = 1'b0;
        mem_address_d = req_addr[ADDR_WIDTH-1:0];
        mem_size_d    = req_funct3[1:0];
        mem_we_d      = req_isStore;
        if (req_isStore) begin
          mem_wdata_d = req_storeData;
        end else begin
          mem_sext_d  = ~req_funct3[2];
        end
      end else begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b1;
        resp_cause_d = req_cause_s;
        resp_data_d  = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCESS: begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_cause_d = 2'd0;
          resp_data_d  = is_store_q ? '0 : mem_readData;
        end
        RESP: begin
          if (resp_fire_s) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
          end else begin
            state_d      = RESP;
          end
        end
        default: begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset drops the write strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_cause_q  <= 2'd0;
      resp_data_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_sext_q    <= 1'b0;
      mem_size_q    <= 2'd0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_store_q    <= is_store_d;
      resp_valid_q  <= resp_valid_d;
      resp_fault_q  <= resp_fault_d;
      resp_cause_q  <= resp_cause_d;
      resp_data_q   <= resp_data_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_sext_q    <= mem_sext_d;
      mem_size_q    <= mem_size_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_fault       = resp_fault_q;
  assign resp_faultCause  = resp_cause_q;
  assign resp_loadData    = resp_data_q;
  assign mem_address      = mem_address_q;
  assign mem_writeData    = mem_wdata_q;
  assign mem_signExtended = mem_sext_q;
  assign mem_writeSize    = mem_size_q;
  assign mem_writeEnable  = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory stub plus a queue-based reference model that
// derives expected responses, latency, ready and write strobes from the request rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_isStore = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0, req_storeData = 64'd0;
  logic        resp_valid, resp_ready = 1'b1, resp_fault;
  logic [63:0] resp_loadData;
  logic [1:0]  resp_faultCause;
  logic [10:0] mem_address;
  logic [63:0] mem_writeData, mem_rd;
  logic        mem_signExtended, mem_writeEnable;
  logic [1:0]  mem_writeSize;

  load_store_unit #(.ADDR_WIDTH(11), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_isStore(req_isStore),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_storeData(req_storeData),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_loadData(resp_loadData),
    .resp_fault(resp_fault), .resp_faultCause(resp_faultCause),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_signExtended(mem_signExtended), .mem_writeSize(mem_writeSize),
    .mem_writeEnable(mem_writeEnable), .mem_readData(mem_rd)
  );

  always #5 clk = ~clk;

  // OnChipDataMemory stand-in: combinational little-endian read, write on the clock edge.
  logic [7:0] dmem [0:2047];
  initial for (int i = 0; i < 2048; i++) dmem[i] <= 8'h00;

  always_comb begin
    mem_rd = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i < (1 << mem_writeSize)) mem_rd[8*i +: 8] = dmem[11'(int'(mem_address) + i)];
    if (mem_signExtended) begin
      case (mem_writeSize)
        2'd0:    mem_rd = {{56{mem_rd[7]}}, mem_rd[7:0]};
        2'd1:    mem_rd = {{48{mem_rd[15]}}, mem_rd[15:0]};
        2'd2:    mem_rd = {{32{mem_rd[31]}}, mem_rd[31:0]};
        default: mem_rd = mem_rd;
      endcase
    end
  end

  always @(posedge clk)
    if (mem_writeEnable)
      for (int i = 0; i < (1 << mem_writeSize); i++)
        dmem[11'(int'(mem_address) + i)] <= mem_writeData[8*i +: 8];

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] data;
    logic        fault;
    logic [1:0]  cause;
    int          acc_cyc;
    bit          st;
    logic [10:0] a;
    logic [63:0] d;
    int          nb;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [0:2047];
  int          tests = 0, failed = 0, cyc = 0;
  bit          acc_phase = 0, acc_we = 0, rnd_ready = 0;
  logic [63:0] last_data;
  logic [1:0]  last_cause;

  function automatic logic [1:0] ref_cause(bit st, logic [2:0] f3, logic [63:0] a);
    logic [63:0] nb = 64'd1 << f3[1:0];
    if ((st && f3[2]) || (!st && f3 == 3'b111)) return 2'd1;
    if ((a % nb) != 64'd0) return 2'd2;
    if (a >= 64'd2048) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [63:0] ref_load(logic [10:0] a, int nb, bit sgn);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (sgn && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check everything at the falling edge, account handshakes, advance past the rising edge.
  task automatic step(output bit acc);
    exp_t e;
    bit   vexp;
    acc = 0;
    @(negedge clk);
    cyc++;
    chk("mem_we", 64'(mem_writeEnable), 64'(acc_phase && acc_we));
    acc_phase = 0;
    if (q.size() == 0) begin
      chk("resp_valid_idle", 64'(resp_valid), 64'd0);
      chk("req_ready_idle", 64'(req_ready), 64'd1);
    end else begin
      e = q[0];
      vexp = (cyc - e.acc_cyc) >= (e.fault ? 1 : 2);
      chk("resp_valid", 64'(resp_valid), 64'(vexp));
      chk("req_ready", 64'(req_ready), vexp ? 64'(resp_ready) : 64'd0);
      if (resp_valid) begin
        chk("resp_data", resp_loadData, e.data);
        chk("resp_fault", 64'(resp_fault), 64'(e.fault));
        chk("resp_cause", 64'(resp_faultCause), 64'(e.cause));
      end
    end
    if (resp_valid && resp_ready && q.size() > 0) begin
      e = q.pop_front();
      last_data  = resp_loadData;
      last_cause = resp_faultCause;
      if (!e.fault && e.st)
        for (int i = 0; i < e.nb; i++) ref_mem[int'(e.a) + i] = e.d[8*i +: 8];
    end
    if (req_valid && req_ready) begin
      acc       = 1;
      e.st      = req_isStore;
      e.cause   = ref_cause(req_isStore, req_funct3, req_addr);
      e.fault   = (e.cause != 2'd0);
      e.a       = req_addr[10:0];
      e.d       = req_storeData;
      e.nb      = 1 << req_funct3[1:0];
      e.data    = (e.fault || e.st) ? 64'd0 : ref_load(e.a, e.nb, !req_funct3[2]);
      e.acc_cyc = cyc;
      if (!e.fault) begin
        acc_phase = 1;
        acc_we    = e.st;
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit st, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] d, input bit keep);
    bit acc = 0;
    int n = 0;
    req_valid = 1; req_isStore = st; req_funct3 = f3; req_addr = a; req_storeData = d;
    while (!acc && n < 50) begin
      step(acc);
      n++;
      if (rnd_ready) resp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("req_accept", 64'(acc), 64'd1);
    if (!keep) req_valid = 0;
  endtask

  task automatic drain();
    bit dummy;
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      step(dummy);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          acc_t [4];
    logic [63:0] lbu_exp [8];
    logic [63:0] a;
    logic [2:0]  f3;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_fault", 64'(resp_fault), 64'd0);
    chk("rst_resp_cause", 64'(resp_faultCause), 64'd0);
    chk("rst_resp_data", resp_loadData, 64'd0);
    chk("rst_mem_addr", 64'(mem_address), 64'd0);
    chk("rst_mem_wdata", mem_writeData, 64'd0);
    chk("rst_mem_size", 64'(mem_writeSize), 64'd0);
    chk("rst_mem_sext", 64'(mem_signExtended), 64'd0);
    chk("rst_mem_we", 64'(mem_writeEnable), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    reset = 0;

    // 1: doubleword store, byte-wise LBU and LD readback
    lbu_exp = '{64'hEF, 64'hCD, 64'hAB, 64'h89, 64'h67, 64'h45, 64'h23, 64'h01};
    send(1, 3'b011, 64'd0, 64'h0123456789ABCDEF, 0);
    for (int i = 0; i < 8; i++) begin
      send(0, 3'b100, 64'(i), 64'd0, 0);
      drain();
      chk("t1_lbu", last_data, lbu_exp[i]);
    end
    send(0, 3'b011, 64'd0, 64'd0, 0);
    drain();
    chk("t1_ld", last_data, 64'h0123456789ABCDEF);

    // 2: signed vs unsigned byte
    send(1, 3'b000, 64'd16, 64'h80, 0);
    send(0, 3'b000, 64'd16, 64'd0, 0);
    drain();
    chk("t2_lb", last_data, 64'hFFFFFFFFFFFFFF80);
    send(0, 3'b100, 64'd16, 64'd0, 0);
    drain();
    chk("t2_lbu", last_data, 64'h80);

    // 3: faults
    send(1, 3'b001, 64'd3, 64'hFFFF, 0);    drain(); chk("t3_mis_sh", 64'(last_cause), 64'd2);
    send(0, 3'b011, 64'h800, 64'd0, 0);     drain(); chk("t3_range_ld", 64'(last_cause), 64'd3);
    send(1, 3'b100, 64'd8, 64'hAA, 0);      drain(); chk("t3_illegal", 64'(last_cause), 64'd1);
    send(0, 3'b001, 64'h801, 64'd0, 0);     drain(); chk("t3_mis_range", 64'(last_cause), 64'd2);
    send(0, 3'b111, 64'd0, 64'd0, 0);       drain(); chk("t3_ldu", 64'(last_cause), 64'd1);

    // 4: writeback stall with a queued request
    resp_ready = 0;
    send(0, 3'b010, 64'd0, 64'd0, 0);
    step(acc);
    step(acc);
    req_valid = 1; req_isStore = 0; req_funct3 = 3'b100; req_addr = 64'd1;
    for (int i = 0; i < 4; i++) begin
      step(acc);
      chk("t4_no_accept", 64'(acc), 64'd0);
    end
    resp_ready = 1;
    step(acc);
    chk("t4_accept", 64'(acc), 64'd1);
    chk("t4_lw", last_data, 64'hFFFFFFFF89ABCDEF);
    req_valid = 0;
    drain();
    chk("t4_lbu", last_data, 64'hCD);

    // 5: reset in the middle of a store ACCESS
    send(1, 3'b010, 64'd32, 64'h11223344, 0);
    drain();
    send(1, 3'b010, 64'd32, 64'hDEADBEEF, 0);
    chk("t5_we_access", 64'(mem_writeEnable), 64'd1);
    reset = 1;
    #1;
    chk("t5_we_drop", 64'(mem_writeEnable), 64'd0);
    chk("t5_valid_rst", 64'(resp_valid), 64'd0);
    q.delete();
    acc_phase = 0;
    @(posedge clk);
    #1;
    chk("t5_valid_rst2", 64'(resp_valid), 64'd0);
    reset = 0;
    send(0, 3'b010, 64'd32, 64'd0, 0);
    drain();
    chk("t5_old", last_data, 64'h11223344);

    // 6: back-to-back loads, one response every two cycles
    for (int i = 0; i < 4; i++) begin
      send(0, 3'b011, 64'(8 * (i & 1)) + 64'd0, 64'd0, 1);
      req_funct3 = 3'b011;
      acc_t[i] = cyc;
      if (i > 0) chk("t6_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'd2);
    end
    req_valid = 0;
    drain();

    // randomized traffic with random writeback backpressure
    rnd_ready = 1;
    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
      send(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    rnd_ready = 0;
    resp_ready = 1;
    req_valid = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
